// File: rtl/onehot_pkg.sv
// Shared one-hot helpers and lane state encoding for the stream demultiplexer.
package onehot_pkg;

    localparam int unsigned DROP_CNT_W   = 8;
    localparam int unsigned ONEHOT_MAX_W = 32;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    // True when exactly one bit is set (callers zero-extend narrower vectors).
    function automatic logic onehot_is_valid(input logic [ONEHOT_MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - ONEHOT_MAX_W'(1))) == '0);
    endfunction

    // Rotate left by one within the low 'width' bits; the top bit wraps to bit 0.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_rotl(
        input logic [ONEHOT_MAX_W-1:0] vec,
        input int unsigned             width
    );
        logic [ONEHOT_MAX_W-1:0] res;
        res = '0;
        for (int unsigned i = 1; i < ONEHOT_MAX_W; i++) begin
            if (i < width) res[i] = vec[i-1];
        end
        for (int unsigned i = 0; i < ONEHOT_MAX_W; i++) begin
            if (i + 1 == width) res[0] = vec[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_demux_dist_if.sv
// Input stream, per-lane output streams and status of the one-hot demultiplexer.
interface onehot_demux_dist_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_LANES = 4
) ();
    import onehot_pkg::*;

    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [DATA_W-1:0]           in_data_i;
    logic [N_LANES-1:0]          sel_i;
    logic                        rr_mode_i;
    logic [N_LANES-1:0]          out_valid_o;
    logic [N_LANES*DATA_W-1:0]   out_data_o;
    logic [N_LANES-1:0]          out_ready_i;
    logic [N_LANES-1:0]          cur_lane_o;
    logic                        sel_err_o;
    logic [DROP_CNT_W-1:0]       drop_cnt_o;

    modport master (
        output in_valid_i, in_data_i, sel_i, rr_mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, cur_lane_o, sel_err_o, drop_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, sel_i, rr_mode_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, cur_lane_o, sel_err_o, drop_cnt_o
    );
endinterface

// File: rtl/onehot_demux_lane.sv
// One output lane: single-entry register with valid/ready, refillable while draining.
module onehot_demux_lane
    import onehot_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    lane_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LANE_EMPTY;
        else         state_q <= state_d;
    end

    // A load while full always coincides with ready, so it simply replaces the entry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LANE_EMPTY: if (load_i)       state_d = LANE_FULL;
            LANE_FULL:  if (!load_i && ready_i) state_d = LANE_EMPTY;
            default:    state_d = LANE_EMPTY;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        data_o  = data_q;
        if (state_q == LANE_FULL) valid_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     data_q <= '0;
        else if (load_i) data_q <= data_i;
    end

endmodule

// File: rtl/onehot_demux_dist.sv
// 1-to-N stream demultiplexer: explicit one-hot or round-robin target, drops malformed selects.
module onehot_demux_dist
    import onehot_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_LANES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    onehot_demux_dist_if.slave bus
);

    logic [N_LANES-1:0]        tgt, load, lane_valid, ptr_q, ptr_d;
    logic [N_LANES*DATA_W-1:0] lane_data;
    logic                      tgt_ok, in_ready, accept, drop, err_q;
    logic [DROP_CNT_W-1:0]     cnt_q, cnt_d;

    // Target decode, acceptance and next pointer/counter values.
    always_comb begin
        tgt      = bus.rr_mode_i ? ptr_q : bus.sel_i;
        tgt_ok   = onehot_is_valid(ONEHOT_MAX_W'(tgt));
        in_ready = tgt_ok ? |(tgt & (~lane_valid | bus.out_ready_i)) : 1'b1;
        accept   = bus.in_valid_i & in_ready;
        load     = (accept && tgt_ok) ? tgt : '0;
        drop     = accept & ~tgt_ok;
        ptr_d    = ptr_q;
        if (accept && bus.rr_mode_i)
            ptr_d = N_LANES'(onehot_rotl(ONEHOT_MAX_W'(ptr_q), N_LANES));
        cnt_d    = cnt_q;
        if (drop && (cnt_q != '1))
            cnt_d = cnt_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= N_LANES'(1);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= drop;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        onehot_demux_lane #(.DATA_W(DATA_W)) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (load[k]),
            .ready_i (bus.out_ready_i[k]),
            .data_i  (bus.in_data_i),
            .valid_o (lane_valid[k]),
            .data_o  (lane_data[k*DATA_W +: DATA_W])
        );
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = lane_valid;
    assign bus.out_data_o  = lane_data;
    assign bus.cur_lane_o  = ptr_q;
    assign bus.sel_err_o   = err_q;
    assign bus.drop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_onehot_demux_dist.sv
// Directed table-driven bench for onehot_demux_dist plus hand-written corner sequences.
module tb_onehot_demux_dist;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    onehot_demux_dist_if #(.DATA_W(8), .N_LANES(4)) bus ();

    onehot_demux_dist #(.DATA_W(8), .N_LANES(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        rr;
        logic [3:0]  sel;
        logic        vld;
        logic [7:0]  data;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_cur;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rr, input logic [3:0] sel, input logic vld,
                         input logic [7:0] data, input logic [3:0] rdy);
        bus.rr_mode_i   = rr;
        bus.sel_i       = sel;
        bus.in_valid_i  = vld;
        bus.in_data_i   = data;
        bus.out_ready_i = rdy;
    endtask

    initial begin
        // rr sel vld data rdy | in_ready valid data cur err cnt
        vecs[0]  = '{1'b1, 4'b0000, 1'b1, 8'h11, 4'b1111, 1'b1, 4'b0001, 32'h00000011, 4'b0010, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h00002211, 4'b0100, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 4'b0000, 1'b1, 8'h33, 4'b1111, 1'b1, 4'b0100, 32'h00332211, 4'b1000, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 4'b0000, 1'b1, 8'h44, 4'b1111, 1'b1, 4'b1000, 32'h44332211, 4'b0001, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 4'b0000, 1'b1, 8'h55, 4'b1111, 1'b1, 4'b0001, 32'h44332255, 4'b0010, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h44332255, 4'b0010, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 4'b0100, 1'b1, 8'hA5, 4'b1011, 1'b1, 4'b0100, 32'h44A52255, 4'b0010, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 4'b0100, 1'b1, 8'h5A, 4'b1011, 1'b0, 4'b0100, 32'h44A52255, 4'b0010, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 4'b0100, 1'b1, 8'h5A, 4'b1111, 1'b1, 4'b0100, 32'h445A2255, 4'b0010, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 4'b0100, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h445A2255, 4'b0010, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 8'h77, 4'b1111, 1'b1, 4'b0000, 32'h445A2255, 4'b0010, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h445A2255, 4'b0010, 1'b0, 8'd1};
        vecs[12] = '{1'b0, 4'b0110, 1'b1, 8'h88, 4'b1111, 1'b1, 4'b0000, 32'h445A2255, 4'b0010, 1'b1, 8'd2};
        vecs[13] = '{1'b0, 4'b0110, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h445A2255, 4'b0010, 1'b0, 8'd2};

        rst_ni = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000);
        #12;
        check("rst_valid", 32'(bus.out_valid_o), 32'h0);
        check("rst_data",  bus.out_data_o,       32'h0);
        check("rst_cur",   32'(bus.cur_lane_o),  32'h1);
        check("rst_err",   32'(bus.sel_err_o),   32'h0);
        check("rst_cnt",   32'(bus.drop_cnt_o),  32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
        check("post_rst_cur", 32'(bus.cur_lane_o), 32'h1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rr, vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready_o), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data", i),  bus.out_data_o,       vecs[i].exp_data);
            check($sformatf("v%0d_cur", i),   32'(bus.cur_lane_o),  32'(vecs[i].exp_cur));
            check($sformatf("v%0d_err", i),   32'(bus.sel_err_o),   32'(vecs[i].exp_err));
            check($sformatf("v%0d_cnt", i),   32'(bus.drop_cnt_o),  32'(vecs[i].exp_cnt));
        end

        // Drop counter saturation: 2 + 260 malformed beats clamps at 255.
        drive(1'b0, 4'b0000, 1'b1, 8'hEE, 4'b1111);
        repeat (260) tick();
        check("sat_cnt",   32'(bus.drop_cnt_o),  32'd255);
        check("sat_err",   32'(bus.sel_err_o),   32'h1);
        check("sat_valid", 32'(bus.out_valid_o), 32'h0);
        drive(1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111);
        tick();
        check("sat_hold_cnt", 32'(bus.drop_cnt_o), 32'd255);
        check("sat_hold_err", 32'(bus.sel_err_o),  32'h0);
        check("sat_cur",      32'(bus.cur_lane_o), 32'b0010);

        // Fill all lanes in rr mode with every lane stalled; pointer wraps back to lane 1.
        drive(1'b1, 4'b0000, 1'b1, 8'hC1, 4'b0000); tick();
        bus.in_data_i = 8'hC2; tick();
        bus.in_data_i = 8'hC3; tick();
        bus.in_data_i = 8'hC0; tick();
        check("fill_valid", 32'(bus.out_valid_o), 32'hF);
        check("fill_data",  bus.out_data_o,       32'hC3C2C1C0);
        check("fill_cur",   32'(bus.cur_lane_o),  32'b0010);

        drive(1'b1, 4'b0000, 1'b1, 8'hD1, 4'b0001);
        #1;
        check("stall_in_ready", 32'(bus.in_ready_o), 32'h0);
        tick();
        check("stall_cur",   32'(bus.cur_lane_o),  32'b0010);
        check("stall_valid", 32'(bus.out_valid_o), 32'b1110);
        check("stall_data",  bus.out_data_o,       32'hC3C2C1C0);

        drive(1'b0, 4'b0001, 1'b1, 8'hD0, 4'b0001);
        #1;
        check("switch_in_ready", 32'(bus.in_ready_o), 32'h1);
        tick();
        check("switch_valid", 32'(bus.out_valid_o), 32'hF);
        check("switch_data",  bus.out_data_o,       32'hC3C2C1D0);
        check("switch_cur",   32'(bus.cur_lane_o),  32'b0010);

        // Asynchronous reset mid-cycle with lanes full.
        drive(1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid_o), 32'h0);
        check("arst_data",  bus.out_data_o,       32'h0);
        check("arst_cur",   32'(bus.cur_lane_o),  32'h1);
        check("arst_cnt",   32'(bus.drop_cnt_o),  32'h0);
        check("arst_err",   32'(bus.sel_err_o),   32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rel_valid", 32'(bus.out_valid_o), 32'h0);
        check("rel_cur",   32'(bus.cur_lane_o),  32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onehot_demux_dist.md
Name: onehot_demux_dist

Overview:
- 1-to-N stream demultiplexer: the distribution-side counterpart of the one-hot N-to-1 select mux.
- Routes an input valid/ready stream to one of N output lanes, chosen either by an explicit one-hot select or by an internal round-robin one-hot pointer.
- Each lane has a one-entry output register with its own valid/ready handshake.
- Malformed (zero-hot or multi-hot) selects are dropped and counted.

Parameters:
- DATA_W, 8, payload width in bits.
- N_LANES, 4, number of output lanes (>=2); select and pointer are N_LANES bits, one-hot.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  input  DATA_W  input payload.
- sel_i  input  N_LANES  one-hot target lane (explicit mode only).
- rr_mode_i  input  1  1 = round-robin target, 0 = sel_i target.
- out_valid_o  output  N_LANES  per-lane valid.
- out_data_o  output  N_LANES*DATA_W  lane k payload at bits [k*DATA_W +: DATA_W].
- out_ready_i  input  N_LANES  per-lane ready.
- cur_lane_o  output  N_LANES  current round-robin pointer, one-hot.
- sel_err_o  output  1  one-cycle pulse on a dropped malformed-select beat.
- drop_cnt_o  output  8  count of dropped beats, saturating.

Behaviour:
- Reset (rst_ni low, async):
  - out_valid_o = 0, out_data_o = 0, cur_lane_o = 'b0..01, sel_err_o = 0, drop_cnt_o = 0.
  - Any in-flight lane data is discarded.
  - Outputs are stable from the first rising edge after release.
- Target vector tgt, combinational:
  - rr_mode_i = 1: tgt = cur_lane_o.
  - rr_mode_i = 0: tgt = sel_i.
- tgt_ok = tgt has exactly one bit set. cur_lane_o always satisfies this.
- Lane k state machine, two states:
  - EMPTY: out_valid_o[k] = 0.
  - FULL: out_valid_o[k] = 1.
  - EMPTY -> FULL on an accepted beat with tgt[k].
  - FULL -> EMPTY on out_ready_i[k] with no new beat for lane k.
  - FULL with out_ready_i[k] and a new beat for lane k: stays FULL, data replaced. Full throughput, no bubble.
  - FULL with !out_ready_i[k]: data and valid held stable.
- in_ready_o, combinational:
  - tgt_ok: in_ready_o = !out_valid_o[t] | out_ready_i[t], where t is the target lane.
  - !tgt_ok: in_ready_o = 1 (drop path, never stalls).
  - Depends on in_valid_i in neither case.
- Latency: accepted beat appears on its lane the next cycle, i.e. 1 cycle.
- Malformed select, explicit mode with !tgt_ok and in_valid_i:
  - Beat consumed; no lane changes.
  - sel_err_o = 1 for the next cycle only.
  - drop_cnt_o increments; it holds at 255 (no wrap).
- Round-robin pointer:
  - On each accepted beat in rr_mode_i = 1, rotate left one bit; MSB wraps to bit 0.
  - It does not move when the target lane stalls, and does not move in explicit mode.
- Mode change takes effect combinationally in the same cycle; the pointer keeps its value across mode switches.
- Lanes drain independently. A stalled lane blocks only beats targeting it (head-of-line at the input is expected).
- in_data_i is captured only on acceptance. Unaccepted input changes have no effect.

Decomposition:
- Shared package onehot_pkg:
  - function onehot_is_valid(vec) (exactly-one-hot check).
  - function onehot_rotl(vec).
  - localparam DROP_CNT_W = 8.
- One sub-module, onehot_demux_lane:
  - Single lane EMPTY/FULL register with load, ready and data.
  - Instantiated N_LANES times via generate.
- Top level holds target selection, in_ready logic, the pointer, and the error/drop counter.

Test Plan:
- Reset, then rr_mode_i=1, all out_ready_i=1, send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back. Required: each appears 1 cycle after accept on lanes 0,1,2,3,0; cur_lane_o sequence 0001,0010,0100,1000,0001.
- Explicit mode, sel_i=0100, out_ready_i[2]=0, send 0xA5 then 0x5A. Required:
  - out_valid_o[2]=1 with 0xA5 held stable.
  - in_ready_o=0 for the second beat.
  - Raising out_ready_i[2] accepts 0x5A that cycle; lane 2 shows 0x5A next cycle with valid kept high.
- Explicit mode, sel_i=0000 then 0110, with in_valid_i. Required: in_ready_o=1; no lane valid; sel_err_o pulses each time; drop_cnt_o = 2.
- 260 consecutive malformed beats. Required: drop_cnt_o saturates at 255 and stays there.
- Lane 1 full and stalled in rr mode, pointer at 0010. Required: input stalls and the pointer holds; switching to explicit sel_i=0001 delivers to lane 0 with the pointer unchanged.
- Assert rst_ni low mid-stream with lanes full. Required: out_valid_o=0 immediately (async), cur_lane_o=0001, drop_cnt_o=0.
